// File: rtl/apb_wait_slave_if.sv
// APB bus bundle between the bridge and the wait-state slave.
// Clock and reset are routed separately as plain ports.
interface apb_wait_slave_if;
  logic       psel;
  logic       penable;
  logic       pwrite;
  logic [7:0] paddr;
  logic [7:0] pwdata;
  logic [7:0] prdata;
  logic       pready;
  logic       pslverr;

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_wait_slave.sv
// APB slave: byte register file, programmable PREADY wait states,
// PSLVERR on illegal access, and a count of completed good transfers.
//
// state  | meaning
// IDLE   | waiting for a setup cycle (PSEL=1, PENABLE=0)
// ACCESS | transfer latched; counting wait cycles down to PREADY
module apb_wait_slave #(
  parameter int DEPTH    = 64,
  parameter int WAIT_RST = 2
) (
  input logic              PCLK,
  input logic              PRESETn,
  apb_wait_slave_if.slave  apb
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t     state_q, state_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic       write_q, write_d;
  logic [2:0] cnt_q, cnt_d;
  logic [2:0] cfg_q, cfg_d;
  logic [7:0] status_q, status_d;
  logic [7:0] mem_q [DEPTH];

  logic       is_mem, is_status, is_cfg, err;
  logic       pready, mem_we;
  logic [7:0] rdata;

  // Decode always uses the latched address, never the live bus
  assign is_mem    = ({1'b0, addr_q} < 9'(DEPTH));
  assign is_status = (addr_q == 8'hFE);
  assign is_cfg    = (addr_q == 8'hFF);
  assign err       = !(is_mem || is_status || is_cfg) || (is_status && write_q);

  assign pready = (state_q == ACCESS) && apb.psel && apb.penable && (cnt_q == 3'd0);

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    write_d  = write_q;
    cnt_d    = cnt_q;
    cfg_d    = cfg_q;
    status_d = status_q;
    mem_we   = 1'b0;
    case (state_q)
      IDLE: begin
        if (apb.psel && !apb.penable) begin
          state_d = ACCESS;
          addr_d  = apb.paddr;
          write_d = apb.pwrite;
          wdata_d = apb.pwdata;
          cnt_d   = cfg_q;
        end
      end
      ACCESS: begin
        if (!apb.psel) begin
          state_d = IDLE;
        end else if (apb.penable) begin
          if (cnt_q != 3'd0) begin
            cnt_d = cnt_q - 3'd1;
          end else begin
            state_d = IDLE;
            if (!err) begin
              status_d = status_q + 8'd1;
              if (write_q && is_mem) mem_we = 1'b1;
              if (write_q && is_cfg) cfg_d  = wdata_q[2:0];
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rdata = 8'h00;
    if (pready && !write_q && !err) begin
      if (is_mem)         rdata = mem_q[addr_q[AW-1:0]];
      else if (is_status) rdata = status_q;
      else                rdata = {5'b0, cfg_q};
    end
  end

  assign apb.pready  = pready;
  assign apb.pslverr = pready && err;
  assign apb.prdata  = rdata;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q  <= IDLE;
      addr_q   <= 8'h00;
      wdata_q  <= 8'h00;
      write_q  <= 1'b0;
      cnt_q    <= 3'd0;
      cfg_q    <= 3'(WAIT_RST);
      status_q <= 8'h00;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      write_q  <= write_d;
      cnt_q    <= cnt_d;
      cfg_q    <= cfg_d;
      status_q <= status_d;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'h00;
    end else if (mem_we) begin
      mem_q[addr_q[AW-1:0]] <= wdata_q;
    end
  end

endmodule
